// File: rtl/register_bank_pkg.sv
// Shared types for the register bank: operation encoding and its width.
package register_bank_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_ROTL = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

endpackage

// File: rtl/register_bank_alu.sv
// Combinational modify unit: computes the next register value, carry-out and
// write enable for one write-port operation.
module register_bank_alu
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             carry_o,
  output logic             we_o
);

  always_comb begin
    nxt_o   = cur_i;
    carry_o = 1'b0;
    we_o    = 1'b1;
    case (op_i)
      OP_NOP: we_o = 1'b0;
      OP_LOAD: nxt_o = wdata_i;
      OP_INC: {carry_o, nxt_o} = {1'b0, cur_i} + (WIDTH+1)'(1);
      OP_DEC: begin
        // Borrow out of the bottom: only a zero operand underflows.
        nxt_o   = cur_i - WIDTH'(1);
        carry_o = (cur_i == '0);
      end
      OP_SHL: begin
        nxt_o   = {cur_i[WIDTH-2:0], 1'b0};
        carry_o = cur_i[WIDTH-1];
      end
      OP_SHR: begin
        nxt_o   = {1'b0, cur_i[WIDTH-1:1]};
        carry_o = cur_i[0];
      end
      OP_ROTL: begin
        nxt_o   = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
        carry_o = cur_i[WIDTH-1];
      end
      OP_CLR: nxt_o = '0;
      default: we_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_bank.sv
// General-purpose register file: DEPTH x WIDTH registers, one write/modify
// port, two combinational read ports, zero/carry flags.
// Optional write-through read bypass: define REGISTER_BANK_BYPASS_EN.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             zero_flag,
  output logic             carry_flag
);

  // DEPTH need not be a power of two, so addresses are range-checked.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             waddr_ok;
  logic             raddr_a_ok;
  logic             raddr_b_ok;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] alu_nxt;
  logic             alu_carry;
  logic             alu_we;
  logic             exec;

  assign waddr_ok   = ({1'b0, waddr}   < DEPTH_C);
  assign raddr_a_ok = ({1'b0, raddr_a} < DEPTH_C);
  assign raddr_b_ok = ({1'b0, raddr_b} < DEPTH_C);
  assign cur_val    = waddr_ok ? regs_q[waddr] : '0;
  assign exec       = waddr_ok && alu_we;

  register_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i    (op_e'(op)),
    .cur_i   (cur_val),
    .wdata_i (wdata),
    .nxt_o   (alu_nxt),
    .carry_o (alu_carry),
    .we_o    (alu_we)
  );

  always_comb begin
    regs_d  = regs_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (exec) begin
      regs_d[waddr] = alu_nxt;
      zero_d        = (alu_nxt == '0);
      carry_d       = alu_carry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    rdata_a = '0;
    if (raddr_a_ok) rdata_a = regs_q[raddr_a];
`ifdef REGISTER_BANK_BYPASS_EN
    if (exec && (raddr_a == waddr)) rdata_a = alu_nxt;
`endif
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b_ok) rdata_b = regs_q[raddr_b];
`ifdef REGISTER_BANK_BYPASS_EN
    if (exec && (raddr_b == waddr)) rdata_b = alu_nxt;
`endif
  end

  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised multi-register block: DEPTH registers of WIDTH bits with one write/modify port and two independent read ports.
- Each write-port operation either loads bus data or modifies the addressed register in place (increment, decrement, shift, rotate, clear), and updates zero/carry flags.
- Serves as the general-purpose register file for the 8-bit CPU datapath.
- Replaces discrete A/B/out registers feeding the bus and ALU.

Parameters:
- WIDTH, 8, bits per register.
- DEPTH, 4, number of registers (>=2, need not be a power of 2).
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- op  input  3  operation code (see Behaviour).
- waddr  input  AW  target register for op.
- wdata  input  WIDTH  load data (used by LOAD only).
- raddr_a  input  AW  read port A address.
- raddr_b  input  AW  read port B address.
- rdata_a  output  WIDTH  register[raddr_a], combinational.
- rdata_b  output  WIDTH  register[raddr_b], combinational.
- zero_flag  output  1  registered: last executed non-NOP result == 0.
- carry_flag  output  1  registered: carry/borrow/shifted-out bit of last executed non-NOP op.

Behaviour:
- Reset: rst low asserts immediately, independent of clk.
  - All registers go to 0; zero_flag=0; carry_flag=0.
  - Reset wins over any op in flight.
  - Release is synchronous to the next clk edge; no op executes on the edge where rst is low.
- Op codes, executed on rising clk, 1-cycle latency; the new value is visible on the read ports after the edge:
  - 0 NOP: nothing changes, flags hold.
  - 1 LOAD: reg<=wdata; C<=0.
  - 2 INC: reg<=reg+1 mod 2^WIDTH; C<=1 iff reg was all ones.
  - 3 DEC: reg<=reg-1 mod 2^WIDTH; C<=1 iff reg was 0 (borrow).
  - 4 SHL: reg<={reg[WIDTH-2:0],0}; C<=old msb.
  - 5 SHR: logical, reg<={0,reg[WIDTH-1:1]}; C<=old lsb.
  - 6 ROTL: reg<={reg[WIDTH-2:0],reg[WIDTH-1]}; C<=old msb.
  - 7 CLR: reg<=0; C<=0.
- Zero flag: for every executed non-NOP op, Z<=(new value==0).
- Invalid write address: waddr>=DEPTH turns any op into NOP. Registers and flags are unchanged.
- Invalid read address: raddr>=DEPTH returns 0 on that port.
- Only one register changes per cycle; all other registers hold.
- Read during write (default build): same-cycle read of waddr returns the old value; the new value appears after the edge.
- Both read ports may address the same register, or the register being written, with no conflict.
- No internal state beyond the registers and the two flags; no FSM stalls, the block is always ready.

Optional Feature:
- Macro REGISTER_BANK_BYPASS_EN.
- Defined: a read port whose address equals waddr, while op is a valid non-NOP, combinationally returns the computed next value (write-through bypass). Flags are unaffected by the bypass.
- Undefined: read ports always return the stored value (old value during a write).

Decomposition:
- Package register_bank_pkg:
  - enum op_e {OP_NOP, OP_LOAD, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_ROTL, OP_CLR}, 3 bits.
  - localparam OP_W=3.
- Sub-module register_bank_alu: purely combinational.
  - Inputs: op, cur value, wdata.
  - Outputs: next value, carry, write-enable (op!=NOP).
  - Parametrised by WIDTH.
  - Used once for the write path and, when bypass is enabled, feeds the read muxes.
- Top holds the register array, flags, address checks and read muxes.

Test Plan:
- Reset: LOAD r1=0x5A, then pulse rst low mid-cycle -> rdata of all regs 0 immediately, Z=0, C=0, no clk edge required.
- Load/read: LOAD r0=0x12, r3=0xF0; raddr_a=0, raddr_b=3 -> 0x12/0xF0; out-of-range raddr (DEPTH=3 build, addr 3) -> 0.
- Wrap: LOAD r2=0xFF, INC r2 -> r2=0x00, Z=1, C=1; DEC r2 -> 0xFF, Z=0, C=1; DEC again -> 0xFE, C=0.
- Shifts: LOAD r1=0x81; SHL -> 0x02, C=1; SHR -> 0x01, C=0; SHR -> 0x00, C=1, Z=1; LOAD 0x81, ROTL -> 0x03, C=1.
- Flag hold/invalid: after Z=1, C=1, apply NOP, then INC with waddr=3 on a DEPTH=3 build -> all regs and flags unchanged.
- Read-during-write: r0=0x07, INC r0 with raddr_a=0 -> 0x07 before edge (0x08 if REGISTER_BANK_BYPASS_EN), 0x08 after edge in both builds.
